// File: rtl/ift_skid_capture.sv
// ift_skid_capture: register stage behind the pmux IFT cell.
// Carries each (Y, Y_t) pair through a 2-entry valid/ready skid buffer
// and keeps running taint statistics on the words it accepts.
module ift_skid_capture #(
  parameter int DATA_W  = 2,
  parameter int TAINT_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [TAINT_W-1:0] in_data_t,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAINT_W-1:0] out_data_t,
  input  logic               clear,
  output logic               taint_seen,
  output logic [CNT_W-1:0]   taint_cnt,
  output logic [TAINT_W-1:0] taint_max
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  state_t               state_reg, state_next;
  logic                 in_ready_reg;
  logic [DATA_W-1:0]    h_data_reg, h_data_next;
  logic [TAINT_W-1:0]   h_tag_reg, h_tag_next;
  logic [DATA_W-1:0]    s_data_reg, s_data_next;
  logic [TAINT_W-1:0]   s_tag_reg, s_tag_next;

  logic                 seen_reg, seen_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [TAINT_W-1:0]   max_reg, max_next;

  logic                 accept;
  logic                 pop;
  logic                 tag_nz;
  logic                 seen_base;
  logic [CNT_W-1:0]     cnt_base;
  logic [TAINT_W-1:0]   max_base;

  assign accept = in_valid & in_ready_reg;
  assign pop    = (state_reg != EMPTY) & out_ready;
  assign tag_nz = |in_data_t;

  // Buffer next-state: data and tag always move as one pair between slots.
  always_comb begin
    state_next  = state_reg;
    h_data_next = h_data_reg;
    h_tag_next  = h_tag_reg;
    s_data_next = s_data_reg;
    s_tag_next  = s_tag_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next  = ONE;
          h_data_next = in_data;
          h_tag_next  = in_data_t;
        end
      end
      ONE: begin
        if (accept && pop) begin
          h_data_next = in_data;
          h_tag_next  = in_data_t;
        end else if (accept) begin
          state_next  = FULL;
          s_data_next = in_data;
          s_tag_next  = in_data_t;
        end else if (pop) begin
          state_next  = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next  = ONE;
          h_data_next = s_data_reg;
          h_tag_next  = s_tag_reg;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Statistics next-state: clear zeroes the base, then a same-cycle accept
  // is folded in so the result reflects that word alone.
  always_comb begin
    seen_base = clear ? 1'b0 : seen_reg;
    cnt_base  = clear ? '0   : cnt_reg;
    max_base  = clear ? '0   : max_reg;
    seen_next = seen_base;
    cnt_next  = cnt_base;
    max_next  = max_base;
    if (accept) begin
      if (tag_nz) begin
        seen_next = 1'b1;
        if (cnt_base != CNT_SAT) begin
          cnt_next = cnt_base + CNT_ONE;
        end
      end
      if (in_data_t > max_base) begin
        max_next = in_data_t;
      end
    end
  end

  // State, entry and statistics registers; in_ready is precomputed from the
  // next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
      h_data_reg   <= '0;
      h_tag_reg    <= '0;
      s_data_reg   <= '0;
      s_tag_reg    <= '0;
      seen_reg     <= 1'b0;
      cnt_reg      <= '0;
      max_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
      h_data_reg   <= h_data_next;
      h_tag_reg    <= h_tag_next;
      s_data_reg   <= s_data_next;
      s_tag_reg    <= s_tag_next;
      seen_reg     <= seen_next;
      cnt_reg      <= cnt_next;
      max_reg      <= max_next;
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = (state_reg != EMPTY);
  assign out_data   = h_data_reg;
  assign out_data_t = h_tag_reg;
  assign taint_seen = seen_reg;
  assign taint_cnt  = cnt_reg;
  assign taint_max  = max_reg;

endmodule

// File: tb/tb_ift_skid_capture.sv
// Bench for ift_skid_capture: directed scenarios followed by random traffic,
// all checked against a queue-based model of a 2-deep FIFO plus statistics.
module tb_ift_skid_capture;

  localparam int DATA_W  = 2;
  localparam int TAINT_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [TAINT_W-1:0] in_data_t;
  logic               out_ready;
  logic               clear;

  logic               in_ready, out_valid, taint_seen;
  logic [DATA_W-1:0]  out_data;
  logic [TAINT_W-1:0] out_data_t, taint_max;
  logic [15:0]        taint_cnt;

  logic               s_in_ready, s_out_valid, s_taint_seen;
  logic [DATA_W-1:0]  s_out_data;
  logic [TAINT_W-1:0] s_out_data_t, s_taint_max;
  logic [1:0]         s_taint_cnt;

  always #5 clk = ~clk;

  ift_skid_capture #(.DATA_W(DATA_W), .TAINT_W(TAINT_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_data_t(in_data_t),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_data_t(out_data_t),
    .clear(clear), .taint_seen(taint_seen),
    .taint_cnt(taint_cnt), .taint_max(taint_max)
  );

  // Narrow-counter copy sharing the same stimulus, to exercise saturation.
  ift_skid_capture #(.DATA_W(DATA_W), .TAINT_W(TAINT_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_data_t(in_data_t),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_data_t(s_out_data_t),
    .clear(clear), .taint_seen(s_taint_seen),
    .taint_cnt(s_taint_cnt), .taint_max(s_taint_max)
  );

  // Reference model: a bounded FIFO of (data, tag) pairs plus statistics.
  typedef struct {
    logic [DATA_W-1:0]  d;
    logic [TAINT_W-1:0] t;
  } word_t;

  word_t              m_q[$];
  logic [DATA_W-1:0]  m_head_d;
  logic [TAINT_W-1:0] m_head_t;
  bit                 m_seen;
  int                 m_cnt;
  int                 m_cnt2;
  logic [TAINT_W-1:0] m_max;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit acc, pp;
    word_t w;
    if (rst) begin
      m_q.delete();
      m_head_d = '0;
      m_head_t = '0;
      m_seen = 0; m_cnt = 0; m_cnt2 = 0; m_max = '0;
      return;
    end
    acc = in_valid && (m_q.size() < 2);
    pp  = (m_q.size() > 0) && out_ready;
    if (pp) void'(m_q.pop_front());
    if (acc) begin
      w.d = in_data;
      w.t = in_data_t;
      m_q.push_back(w);
    end
    if (m_q.size() > 0) begin
      m_head_d = m_q[0].d;
      m_head_t = m_q[0].t;
    end
    if (clear) begin
      m_seen = 0; m_cnt = 0; m_cnt2 = 0; m_max = '0;
    end
    if (acc) begin
      if (in_data_t != 0) begin
        m_seen = 1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (in_data_t > m_max) m_max = in_data_t;
    end
  endtask

  task automatic compare_all();
    check("in_ready",   64'(in_ready),    64'(m_q.size() < 2));
    check("out_valid",  64'(out_valid),   64'(m_q.size() > 0));
    check("out_data",   64'(out_data),    64'(m_head_d));
    check("out_data_t", 64'(out_data_t),  64'(m_head_t));
    check("taint_seen", 64'(taint_seen),  64'(m_seen));
    check("taint_cnt",  64'(taint_cnt),   64'(m_cnt));
    check("taint_max",  64'(taint_max),   64'(m_max));
    check("sat_cnt",    64'(s_taint_cnt), 64'(m_cnt2));
    check("sat_ready",  64'(s_in_ready),  64'(m_q.size() < 2));
    $display("cyc t=%0t rst=%0b iv=%0b d=%0h t=%0h ordy=%0b clr=%0b -> ov=%0b od=%0h ot=%0h cnt=%0d max=%0h",
             $time, rst, in_valid, in_data, in_data_t, out_ready, clear,
             out_valid, out_data, out_data_t, taint_cnt, taint_max);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [TAINT_W-1:0] t, input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    in_data_t = t;
    out_ready = ordy;
    clear     = clr;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = '0; in_data_t = '0; out_ready = 0; clear = 0;
    tick();
    tick();
    rst = 1'b0;
    drive(0, 2'b00, 32'h0, 0, 0);

    // Streaming with downstream always ready.
    drive(1, 2'b00, 32'h0, 1, 0);
    drive(1, 2'b10, 32'h1, 1, 0);
    drive(1, 2'b11, 32'h4, 1, 0);
    drive(0, 2'b00, 32'h0, 1, 0);
    drive(0, 2'b00, 32'h0, 1, 0);

    // Backpressure into FULL, then release.
    drive(1, 2'b01, 32'h2, 0, 0);
    drive(1, 2'b11, 32'h0, 0, 0);
    drive(1, 2'b10, 32'h7, 0, 0);
    drive(0, 2'b00, 32'h0, 0, 0);
    drive(0, 2'b00, 32'h0, 1, 0);
    drive(0, 2'b00, 32'h0, 1, 0);
    drive(0, 2'b00, 32'h0, 1, 0);

    // Simultaneous accept and pop over eight words.
    for (int i = 0; i < 8; i++) begin
      drive(1, DATA_W'(i), TAINT_W'(i * 3), 1, 0);
    end
    drive(0, 2'b00, 32'h0, 1, 0);

    // Clear colliding with a tainted accept, then clear alone.
    drive(1, 2'b10, 32'h3, 1, 1);
    drive(0, 2'b00, 32'h0, 1, 1);
    drive(0, 2'b00, 32'h0, 1, 0);

    // Saturation of the narrow counter.
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b01, 32'h10 + TAINT_W'(i), 1, 0);
    end
    drive(0, 2'b00, 32'h0, 1, 0);

    // Reset while FULL.
    drive(1, 2'b01, 32'h5, 0, 0);
    drive(1, 2'b10, 32'h6, 0, 0);
    rst = 1'b1;
    drive(0, 2'b00, 32'h0, 0, 0);
    rst = 1'b0;
    drive(0, 2'b00, 32'h0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 3) != 0),
            DATA_W'($urandom),
            ($urandom_range(0, 1) != 0) ? TAINT_W'($urandom) : '0,
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 29) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
